// File: rtl/datapath_hs_pkg.sv
// Shared types for datapath_hs: opcode constants, ALU op, register-input select, FSM state.
package datapath_hs_pkg;

  localparam logic [3:0] OpAdd  = 4'd2;
  localparam logic [3:0] OpSub  = 4'd3;
  localparam logic [3:0] OpNor  = 4'd4;
  localparam logic [3:0] OpAnd  = 4'd5;
  localparam logic [3:0] OpXor  = 4'd6;
  localparam logic [3:0] OpRsh1 = 4'd7;

  typedef enum logic [2:0] {AluAdd, AluSub, AluNor, AluAnd, AluXor, AluRsh1} alu_op_e;

  typedef enum logic [1:0] {
    RegInAlu  = 2'd0,
    RegInImm  = 2'd1,
    RegInLoad = 2'd2,
    RegInZero = 2'd3
  } reg_in_sel_e;

  typedef enum logic {StRun = 1'b0, StWait = 1'b1} state_e;

  // Unlisted opcodes fall back to add.
  function automatic alu_op_e decode_alu_op(input logic [3:0] op);
    case (op)
      OpSub:   return AluSub;
      OpNor:   return AluNor;
      OpAnd:   return AluAnd;
      OpXor:   return AluXor;
      OpRsh1:  return AluRsh1;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/datapath_hs_call_stack_g.sv
// Return-address stack for datapath_hs. DATAPATH_HS_CS_GUARD_EN enables overflow/underflow
// guarding with sticky flags; otherwise the pointer simply wraps modulo CS_DEPTH.
module call_stack_g
  import datapath_hs_pkg::*;
#(
  parameter int unsigned CS_DEPTH = 16,
  parameter int unsigned PC_W     = 10
) (
  input  logic            clk_i,
  input  logic            sync_rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] pop_data_o,
  output logic            ovf_o,
  output logic            unf_o
);

  localparam int unsigned IdxW = $clog2(CS_DEPTH);
`ifdef DATAPATH_HS_CS_GUARD_EN
  localparam int unsigned SpW = IdxW + 1;
`else
  localparam int unsigned SpW = IdxW;
`endif

  logic [PC_W-1:0] mem_q [CS_DEPTH];
  logic [SpW-1:0]  sp_q, sp_d;
  logic [IdxW-1:0] wr_idx, top_idx;
  logic            push_ok, pop_ok;

  assign wr_idx  = sp_q[IdxW-1:0];
  assign top_idx = wr_idx - IdxW'(1);

`ifdef DATAPATH_HS_CS_GUARD_EN
  logic full, empty, ovf_q, unf_q;

  assign full       = (sp_q == SpW'(CS_DEPTH));
  assign empty      = (sp_q == '0);
  assign push_ok    = push_i & ~full;
  assign pop_ok     = pop_i & ~empty;
  // Underflow returns address 0.
  assign pop_data_o = empty ? '0 : mem_q[top_idx];
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push_i && !pop_i && full) ovf_q <= 1'b1;
      if (pop_i && empty)           unf_q <= 1'b1;
    end
  end
`else
  assign push_ok    = push_i;
  assign pop_ok     = pop_i;
  assign pop_data_o = mem_q[top_idx];
  assign ovf_o      = 1'b0;
  assign unf_o      = 1'b0;
`endif

  always_comb begin
    sp_d = sp_q;
    if (pop_ok)       sp_d = sp_q - SpW'(1);
    else if (push_ok) sp_d = sp_q + SpW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      sp_q <= '0;
      for (int i = 0; i < CS_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q <= sp_d;
      if (push_ok && !pop_ok) mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/datapath_hs.sv
// Parametrised datapath: register file, ALU, flags, PC and call stack with a req/ack memory
// handshake that stalls the PC. Build option: DATAPATH_HS_CS_GUARD_EN (call-stack guarding).
module datapath_hs
  import datapath_hs_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PC_W     = 10,
  parameter int unsigned CS_DEPTH = 16
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic [15:0]       inst_bus,
  input  logic              reg_we,
  input  logic [1:0]        reg_in_sel,
  input  logic              alu_b_sel,
  input  logic              flags_we,
  input  logic              flags_sel,
  input  logic              pc_en,
  input  logic              pc_jmp,
  input  logic              cs_push,
  input  logic              cs_pop,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [DATA_W-1:0] load_bus,
  input  logic              mem_ack,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr_bus,
  output logic [DATA_W-1:0] store_bus,
  output logic [PC_W-1:0]   inst_addr_bus,
  output logic              flag_out,
  output logic              busy,
  output logic              cs_ovf,
  output logic              cs_unf
);

  logic [3:0]        op, ra, rb, rc;
  logic [7:0]        imm;
  logic [DATA_W-1:0] imm_ext, rd_a, rd_b, alu_b, addr_c;
  logic [DATA_W:0]   alu_res;
  alu_op_e           alu_op;
  reg_in_sel_e       in_sel;

  logic [DATA_W-1:0] rf_q [16];
  logic              rf_we;
  logic [3:0]        rf_idx;
  logic [DATA_W-1:0] rf_data;

  state_e            state_q;
  logic              mem_re_q, mem_we_q;
  logic [DATA_W-1:0] addr_q, store_q;
  logic [3:0]        dest_q;
  logic              carry_q, zero_q;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc, pop_pc;
  logic              run, mem_req, ctl_ok;

  assign op      = inst_bus[15:12];
  assign ra      = inst_bus[11:8];
  assign rb      = inst_bus[7:4];
  assign rc      = inst_bus[3:0];
  assign imm     = inst_bus[7:0];
  assign imm_ext = DATA_W'(imm);
  assign in_sel  = reg_in_sel_e'(reg_in_sel);
  assign alu_op  = decode_alu_op(op);

  // r0 is never written and resets to zero, so it always reads zero.
  assign rd_a   = rf_q[ra];
  assign rd_b   = rf_q[rb];
  assign alu_b  = alu_b_sel ? imm_ext : rd_b;
  assign addr_c = rd_a + {{(DATA_W-4){inst_bus[3]}}, inst_bus[3:0]};

  always_comb begin
    alu_res = '0;
    case (alu_op)
      AluSub:  alu_res = {1'b0, rd_a} + {1'b0, ~alu_b} + {{DATA_W{1'b0}}, 1'b1};
      AluNor:  alu_res = {1'b0, ~(rd_a | alu_b)};
      AluAnd:  alu_res = {1'b0, rd_a & alu_b};
      AluXor:  alu_res = {1'b0, rd_a ^ alu_b};
      AluRsh1: alu_res = {2'b00, rd_a[DATA_W-1:1]};
      default: alu_res = {1'b0, rd_a} + {1'b0, alu_b};
    endcase
  end

  assign run     = (state_q == StRun);
  assign mem_req = ld_req | st_req;
  // A memory request freezes PC and stack on its issuing edge.
  assign ctl_ok  = run & ~mem_req;

  // Imm forms overlap B/C with the immediate, so they target register A.
  always_comb begin
    rf_we   = 1'b0;
    rf_idx  = (alu_b_sel || in_sel == RegInImm) ? ra : rc;
    rf_data = '0;
    if (run) begin
      rf_we = reg_we;
      case (in_sel)
        RegInAlu:  rf_data = alu_res[DATA_W-1:0];
        RegInImm:  rf_data = imm_ext;
        RegInLoad: rf_data = load_bus;
        default:   rf_data = '0;
      endcase
    end else if (mem_ack && mem_re_q) begin
      rf_we   = 1'b1;
      rf_idx  = dest_q;
      rf_data = load_bus;
    end
    if (rf_idx == 4'd0) rf_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_idx] <= rf_data;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (run && flags_we) begin
      carry_q <= alu_res[DATA_W];
      zero_q  <= (alu_res[DATA_W-1:0] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q  <= StRun;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      dest_q   <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (mem_req) begin
            addr_q   <= addr_c;
            store_q  <= rd_b;
            dest_q   <= rc;
            mem_re_q <= ld_req;
            mem_we_q <= ~ld_req;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (mem_ack) begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    pc_d = pc_q;
    if (ctl_ok) begin
      if (cs_pop)      pc_d = pop_pc;
      else if (pc_jmp) pc_d = inst_bus[PC_W-1:0];
      else if (pc_en)  pc_d = pc_inc;
    end else if (!run && mem_ack) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) pc_q <= '0;
    else          pc_q <= pc_d;
  end

  call_stack_g #(
    .CS_DEPTH(CS_DEPTH),
    .PC_W    (PC_W)
  ) u_call_stack (
    .clk_i      (clk),
    .sync_rst_i (sync_rst),
    .push_i     (ctl_ok & cs_push & ~cs_pop),
    .pop_i      (ctl_ok & cs_pop),
    .push_data_i(pc_inc),
    .pop_data_o (pop_pc),
    .ovf_o      (cs_ovf),
    .unf_o      (cs_unf)
  );

  assign mem_re        = mem_re_q;
  assign mem_we        = mem_we_q;
  assign busy          = ~run;
  assign mem_addr_bus  = run ? addr_c : addr_q;
  assign store_bus     = run ? rd_b : store_q;
  assign inst_addr_bus = pc_q;
  assign flag_out      = flags_sel ? carry_q : zero_q;

endmodule

// File: tb/tb_datapath_hs.sv
// Directed bench for datapath_hs: ALU vector table plus hand-written memory/stack sequences.
module tb_datapath_hs;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PC_W     = 10;
  localparam int unsigned CS_DEPTH = 16;

  logic              clk = 1'b0;
  logic              sync_rst = 1'b1;
  logic [15:0]       inst_bus;
  logic              reg_we, alu_b_sel, flags_we, flags_sel, pc_en, pc_jmp;
  logic              cs_push, cs_pop, ld_req, st_req, mem_ack;
  logic [1:0]        reg_in_sel;
  logic [DATA_W-1:0] load_bus;
  logic              mem_re, mem_we, flag_out, busy, cs_ovf, cs_unf;
  logic [DATA_W-1:0] mem_addr_bus, store_bus;
  logic [PC_W-1:0]   inst_addr_bus;

  always #5 clk = ~clk;

  datapath_hs #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .CS_DEPTH(CS_DEPTH)
  ) dut (
    .clk          (clk),
    .sync_rst     (sync_rst),
    .inst_bus     (inst_bus),
    .reg_we       (reg_we),
    .reg_in_sel   (reg_in_sel),
    .alu_b_sel    (alu_b_sel),
    .flags_we     (flags_we),
    .flags_sel    (flags_sel),
    .pc_en        (pc_en),
    .pc_jmp       (pc_jmp),
    .cs_push      (cs_push),
    .cs_pop       (cs_pop),
    .ld_req       (ld_req),
    .st_req       (st_req),
    .load_bus     (load_bus),
    .mem_ack      (mem_ack),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr_bus (mem_addr_bus),
    .store_bus    (store_bus),
    .inst_addr_bus(inst_addr_bus),
    .flag_out     (flag_out),
    .busy         (busy),
    .cs_ovf       (cs_ovf),
    .cs_unf       (cs_unf)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
  } alu_vec_t;

  alu_vec_t vecs [10];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_bus   = '0;
    reg_we     = 1'b0;
    reg_in_sel = 2'd0;
    alu_b_sel  = 1'b0;
    flags_we   = 1'b0;
    flags_sel  = 1'b0;
    pc_en      = 1'b0;
    pc_jmp     = 1'b0;
    cs_push    = 1'b0;
    cs_pop     = 1'b0;
    ld_req     = 1'b0;
    st_req     = 1'b0;
    mem_ack    = 1'b0;
    load_bus   = '0;
  endtask

  task automatic do_reset();
    idle();
    sync_rst = 1'b1;
    tick();
    tick();
    sync_rst = 1'b0;
  endtask

  task automatic ldi(input logic [3:0] r, input logic [7:0] v);
    idle();
    inst_bus   = {4'h0, r, v};
    reg_we     = 1'b1;
    reg_in_sel = 2'd1;
    tick();
    idle();
  endtask

  // Register read through store_bus (reg B) while in RUN.
  task automatic rd(input logic [3:0] r, output logic [7:0] v);
    idle();
    inst_bus = {8'h00, r, 4'h0};
    #1;
    v = store_bus;
  endtask

  task automatic call(input logic [PC_W-1:0] target);
    idle();
    inst_bus = 16'(target);
    cs_push  = 1'b1;
    pc_jmp   = 1'b1;
    tick();
    idle();
  endtask

  task automatic ret();
    idle();
    cs_pop = 1'b1;
    tick();
    idle();
  endtask

  logic [7:0] v;
  logic       guard_on;

  initial begin
`ifdef DATAPATH_HS_CS_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    vecs[0] = '{4'h2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[1] = '{4'h2, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    vecs[2] = '{4'h3, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{4'h3, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{4'h4, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{4'h5, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vecs[6] = '{4'h6, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0};
    vecs[7] = '{4'h7, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0};
    vecs[8] = '{4'h0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{4'hF, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};

    do_reset();
    check("rst_pc", 32'(inst_addr_bus), 32'h0);
    check("rst_mem_re", 32'(mem_re), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(cs_ovf), 32'h0);
    check("rst_unf", 32'(cs_unf), 32'h0);
    check("rst_zero_flag", 32'(flag_out), 32'h0);
    flags_sel = 1'b1;
    #1 check("rst_carry_flag", 32'(flag_out), 32'h0);
    for (int r = 1; r < 16; r++) begin
      rd(4'(r), v);
      check($sformatf("rst_r%0d", r), 32'(v), 32'h0);
    end

    // ALU table: r1 op r2 -> r3, flags updated.
    for (int i = 0; i < 10; i++) begin
      ldi(4'h1, vecs[i].a);
      ldi(4'h2, vecs[i].b);
      inst_bus = {vecs[i].op, 4'h1, 4'h2, 4'h3};
      reg_we   = 1'b1;
      flags_we = 1'b1;
      tick();
      idle();
      rd(4'h3, v);
      check($sformatf("alu%0d_res", i), 32'(v), 32'(vecs[i].res));
      flags_sel = 1'b1;
      #1 check($sformatf("alu%0d_carry", i), 32'(flag_out), 32'(vecs[i].c));
      flags_sel = 1'b0;
      #1 check($sformatf("alu%0d_zero", i), 32'(flag_out), 32'(vecs[i].z));
    end

    // Imm form writes register A; r0 writes are dropped; zero select clears C.
    ldi(4'h4, 8'h10);
    inst_bus  = {4'h2, 4'h4, 8'h05};
    reg_we    = 1'b1;
    alu_b_sel = 1'b1;
    tick();
    rd(4'h4, v);
    check("imm_add_r4", 32'(v), 32'h15);
    ldi(4'h0, 8'h77);
    rd(4'h0, v);
    check("r0_reads_zero", 32'(v), 32'h0);
    inst_bus   = {4'h0, 4'h0, 4'h0, 4'h4};
    reg_we     = 1'b1;
    reg_in_sel = 2'd3;
    tick();
    rd(4'h4, v);
    check("zero_sel_r4", 32'(v), 32'h0);

    // Load with 3-cycle wait, sign-extended offset -2, dest r14.
    do_reset();
    ldi(4'h1, 8'h20);
    inst_bus = {4'h0, 4'h1, 4'h0, 4'hE};
    ld_req   = 1'b1;
    #1 check("ld_addr_comb", 32'(mem_addr_bus), 32'h1E);
    tick();
    idle();
    pc_en = 1'b1;
    check("ld_busy1", 32'(busy), 32'h1);
    check("ld_mem_re", 32'(mem_re), 32'h1);
    check("ld_mem_we", 32'(mem_we), 32'h0);
    check("ld_addr_held", 32'(mem_addr_bus), 32'h1E);
    check("ld_pc_frozen1", 32'(inst_addr_bus), 32'h0);
    tick();
    check("ld_busy2", 32'(busy), 32'h1);
    check("ld_pc_frozen2", 32'(inst_addr_bus), 32'h0);
    tick();
    check("ld_busy3", 32'(busy), 32'h1);
    mem_ack  = 1'b1;
    load_bus = 8'h5A;
    tick();
    idle();
    check("ld_busy_done", 32'(busy), 32'h0);
    check("ld_mem_re_drop", 32'(mem_re), 32'h0);
    check("ld_pc_inc", 32'(inst_addr_bus), 32'h1);
    rd(4'hE, v);
    check("ld_r14", 32'(v), 32'h5A);

    // ld and st together: load wins; ack in first strobe cycle.
    inst_bus = {4'h0, 4'h1, 4'h2, 4'h3};
    ld_req   = 1'b1;
    st_req   = 1'b1;
    tick();
    idle();
    check("ldst_mem_re", 32'(mem_re), 32'h1);
    check("ldst_mem_we", 32'(mem_we), 32'h0);
    mem_ack  = 1'b1;
    load_bus = 8'hC3;
    tick();
    idle();
    check("ldst_busy", 32'(busy), 32'h0);
    check("ldst_pc", 32'(inst_addr_bus), 32'h2);
    rd(4'h3, v);
    check("ldst_r3", 32'(v), 32'hC3);

    // Store: data and address held from capture.
    ldi(4'h2, 8'h99);
    inst_bus = {4'h0, 4'h1, 4'h2, 4'h1};
    st_req   = 1'b1;
    tick();
    idle();
    check("st_mem_we", 32'(mem_we), 32'h1);
    check("st_mem_re", 32'(mem_re), 32'h0);
    check("st_data", 32'(store_bus), 32'h99);
    check("st_addr", 32'(mem_addr_bus), 32'h21);
    mem_ack = 1'b1;
    tick();
    idle();
    check("st_mem_we_drop", 32'(mem_we), 32'h0);
    check("st_pc", 32'(inst_addr_bus), 32'h3);

    mem_ack = 1'b1;
    tick();
    idle();
    check("ack_in_run_pc", 32'(inst_addr_bus), 32'h3);
    check("ack_in_run_busy", 32'(busy), 32'h0);

    // Reset during WAIT aborts the load.
    inst_bus = {4'h0, 4'h1, 4'h0, 4'h9};
    ld_req   = 1'b1;
    tick();
    idle();
    sync_rst = 1'b1;
    mem_ack  = 1'b1;
    load_bus = 8'hEE;
    tick();
    sync_rst = 1'b0;
    idle();
    check("rstwait_mem_re", 32'(mem_re), 32'h0);
    check("rstwait_busy", 32'(busy), 32'h0);
    rd(4'h9, v);
    check("rstwait_r9", 32'(v), 32'h0);

    // Call/return, push+pop = pop only, then pop on empty.
    pc_en = 1'b1;
    repeat (5) tick();
    idle();
    check("pc_five", 32'(inst_addr_bus), 32'h5);
    call(10'h100);
    check("call_pc", 32'(inst_addr_bus), 32'h100);
    ret();
    check("ret_pc", 32'(inst_addr_bus), 32'h6);
    call(10'h100);
    inst_bus = 16'h0200;
    cs_push  = 1'b1;
    cs_pop   = 1'b1;
    pc_jmp   = 1'b1;
    tick();
    idle();
    check("pushpop_pc", 32'(inst_addr_bus), 32'h7);
    ret();
    check("unf_pc", 32'(inst_addr_bus), 32'h0);
    check("unf_flag", 32'(cs_unf), 32'(guard_on));
    check("unf_no_ovf", 32'(cs_ovf), 32'h0);
    do_reset();
    check("unf_cleared", 32'(cs_unf), 32'h0);

    // CS_DEPTH+1 calls; call k pushes 1 (k=0) or 0x100+k.
    for (int k = 0; k <= CS_DEPTH; k++) begin
      call(PC_W'(32'h100 + k));
      if (k == CS_DEPTH - 1) check("ovf_at_full", 32'(cs_ovf), 32'h0);
    end
    check("ovf_flag", 32'(cs_ovf), 32'(guard_on));
    ret();
    check("ovf_first_pop", 32'(inst_addr_bus), guard_on ? 32'h10F : 32'h110);
    for (int k = 1; k < CS_DEPTH; k++) ret();
    check("ovf_last_pop", 32'(inst_addr_bus), guard_on ? 32'h1 : 32'h101);
    check("ovf_sticky", 32'(cs_ovf), 32'(guard_on));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
